// File: rtl/hyperram_pattern_tester.sv
// Pattern write/read-back tester for the HyperRAM controller's user command port.
// Writes an additive pattern sequence to consecutive word addresses, then reads and compares.
module hyperram_pattern_tester #(
  parameter int unsigned ADDR_WIDTH     = 22,
  parameter int unsigned WORD_COUNT     = 16,
  parameter logic [31:0] SEED           = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  userClock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddress,
  output logic                  commandEnable,
  output logic                  commandRead,
  output logic [ADDR_WIDTH-1:0] commandAddress,
  output logic [31:0]           writeData,
  input  logic                  controllerBusy,
  input  logic                  readDataValid,
  input  logic [31:0]           readData,
  output logic [31:0]           readReg,
  output logic                  testBusy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           errorCount,
  output logic [ADDR_WIDTH-1:0] firstErrorAddress
);

  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] PAT_STEP = 32'h9E3779B9;
  localparam logic [15:0] IDX_LAST = 16'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           idx_q, idx_d;
  logic [31:0]           pat_q, pat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic                  tout_q, tout_d;
  logic                  got_q, got_d;
  logic [31:0]           rreg_q, rreg_d;

  logic last_word;
  logic guard;
  logic expired;

  // tmo_q counts cycles since the last issue, so 1 marks the first (guard) wait cycle.
  assign last_word = (idx_q == IDX_LAST);
  assign guard     = (tmo_q == TW'(1));
  assign expired   = (32'(tmo_q) + 32'd1) >= 32'(TIMEOUT_CYCLES);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    addr_d  = addr_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    tout_d  = tout_q;
    got_d   = got_q;
    rreg_d  = rreg_q;

    if (readDataValid) rreg_d = readData;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d  = '0;
          pat_d  = SEED;
          addr_d = baseAddress;
          base_d = baseAddress;
          err_d  = '0;
          ferr_d = '0;
          tout_d = 1'b0;
          got_d  = 1'b0;
          tmo_d  = TW'(1);
          if (controllerBusy) begin
            state_d = S_ARM;
          end else begin
            wdata_d = SEED;
            state_d = S_WR_ISSUE;
          end
        end
      end
      S_ARM: begin
        tmo_d = tmo_q + TW'(1);
        if (!controllerBusy) begin
          wdata_d = pat_q;
          state_d = S_WR_ISSUE;
        end else if (expired) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR_ISSUE: begin
        tmo_d   = TW'(1);
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (!guard && !controllerBusy) begin
          if (last_word) begin
            idx_d   = '0;
            pat_d   = SEED;
            addr_d  = base_q;
            got_d   = 1'b0;
            state_d = S_RD_ISSUE;
          end else begin
            idx_d   = idx_q + 16'd1;
            pat_d   = pat_q + PAT_STEP;
            addr_d  = addr_q + ADDR_WIDTH'(2);
            wdata_d = pat_q + PAT_STEP;
            state_d = S_WR_ISSUE;
          end
        end else if (expired) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RD_ISSUE: begin
        tmo_d   = TW'(1);
        got_d   = 1'b0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (readDataValid && !got_q) begin
          got_d = 1'b1;
          if (readData != pat_q) begin
            if (err_q != '1) err_d = err_q + 16'd1;
            if (err_q == '0) ferr_d = addr_q;
          end
        end
        // Strobe and busy release may land in the same cycle; both are honoured here.
        if ((got_q || readDataValid) && !guard && !controllerBusy) begin
          got_d = 1'b0;
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            pat_d   = pat_q + PAT_STEP;
            addr_d  = addr_q + ADDR_WIDTH'(2);
            state_d = S_RD_ISSUE;
          end
        end else if (expired) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge userClock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      tout_q  <= 1'b0;
      got_q   <= 1'b0;
      rreg_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      tout_q  <= tout_d;
      got_q   <= got_d;
      rreg_q  <= rreg_d;
    end
  end

  assign commandEnable     = (state_q == S_WR_ISSUE) || (state_q == S_RD_ISSUE);
  assign commandRead       = (state_q == S_RD_ISSUE);
  assign commandAddress    = addr_q;
  assign writeData         = wdata_q;
  assign readReg           = rreg_q;
  assign testBusy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done              = (state_q == S_DONE);
  assign pass              = (state_q == S_DONE) && (err_q == '0) && !tout_q;
  assign timeout           = tout_q;
  assign errorCount        = err_q;
  assign firstErrorAddress = ferr_q;

endmodule

// File: tb/tb_hyperram_pattern_tester.sv
// Directed bench for hyperram_pattern_tester with a small behavioural controller/memory model.
module tb_hyperram_pattern_tester;

  localparam int AW = 22;
  localparam int TO = 64;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] baseAddress;
  logic          commandEnable;
  logic          commandRead;
  logic [AW-1:0] commandAddress;
  logic [31:0]   writeData;
  logic          controllerBusy;
  logic          readDataValid;
  logic [31:0]   readData;
  logic [31:0]   readReg;
  logic          testBusy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [15:0]   errorCount;
  logic [AW-1:0] firstErrorAddress;

  hyperram_pattern_tester #(
    .ADDR_WIDTH    (AW),
    .WORD_COUNT    (3),
    .SEED          (32'h00000000),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .userClock        (clk),
    .reset            (reset),
    .start            (start),
    .baseAddress      (baseAddress),
    .commandEnable    (commandEnable),
    .commandRead      (commandRead),
    .commandAddress   (commandAddress),
    .writeData        (writeData),
    .controllerBusy   (controllerBusy),
    .readDataValid    (readDataValid),
    .readData         (readData),
    .readReg          (readReg),
    .testBusy         (testBusy),
    .done             (done),
    .pass             (pass),
    .timeout          (timeout),
    .errorCount       (errorCount),
    .firstErrorAddress(firstErrorAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Controller/memory model: busy for two cycles after each strobe, read data with the busy release.
  logic          mdl_busy, mdl_rdv, ext_busy, stray_rdv;
  logic [31:0]   mdl_rdata, stray_data;
  logic [31:0]   mem [logic [AW-1:0]];
  logic          corrupt_en, drop_en, b2b, prev_en, pend_rd;
  logic [AW-1:0] corrupt_addr, drop_addr, rd_addr;
  int            cnt;
  logic [AW-1:0] s_addr[$];
  logic          s_rd[$];
  logic [31:0]   s_data[$];
  int            s_cyc[$];

  assign controllerBusy = mdl_busy | ext_busy;
  assign readDataValid  = mdl_rdv | stray_rdv;
  assign readData       = stray_rdv ? stray_data : mdl_rdata;

  initial begin
    mdl_busy = 0; mdl_rdv = 0; mdl_rdata = '0; cnt = 0; pend_rd = 0; prev_en = 0; b2b = 0;
    rd_addr = '0;
    forever begin
      @(posedge clk); #1;
      mdl_rdv = 0;
      if (reset) begin
        cnt = 0; pend_rd = 0; mdl_busy = 0; prev_en = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mdl_busy = 0;
            if (pend_rd && !(drop_en && rd_addr == drop_addr)) begin
              mdl_rdv   = 1;
              mdl_rdata = (corrupt_en && rd_addr == corrupt_addr) ? 32'hDEADBEEF : mem[rd_addr];
            end
            pend_rd = 0;
          end
        end
        if (commandEnable) begin
          if (prev_en) b2b = 1;
          s_addr.push_back(commandAddress);
          s_rd.push_back(commandRead);
          s_data.push_back(writeData);
          s_cyc.push_back(cyc);
          if (!commandRead) mem[commandAddress] = writeData;
          else begin
            pend_rd = 1;
            rd_addr = commandAddress;
          end
          mdl_busy = 1;
          cnt      = 2;
        end
        prev_en = commandEnable;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_log();
    s_addr.delete(); s_rd.delete(); s_data.delete(); s_cyc.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    baseAddress = base;
    start = 1;
    step(1);
    start = 0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step(1);
      n++;
    end
    check("done_within_budget", {31'd0, done}, 32'd1);
    dc = cyc;
  endtask

  localparam logic [31:0] P0 = 32'h00000000;
  localparam logic [31:0] P1 = 32'h9E3779B9;
  localparam logic [31:0] P2 = 32'h3C6EF372;

  int dc, bcyc, nrd, nlog;

  initial begin
    reset = 1; start = 0; baseAddress = '0; ext_busy = 0; stray_rdv = 0; stray_data = '0;
    corrupt_en = 0; drop_en = 0; corrupt_addr = '0; drop_addr = '0;
    step(3);
    reset = 0;
    step(1);
    check("rst_ctl", {26'd0, commandEnable, commandRead, testBusy, done, pass, timeout}, 32'd0);
    check("rst_addr", 32'(commandAddress), 32'd0);
    check("rst_err", {16'd0, errorCount}, 32'd0);

    // Clean pass
    clear_log();
    do_start(22'h100);
    check("t1_busy_first", {30'd0, testBusy, commandEnable}, 32'd3);
    wait_done(200, dc);
    check("t1_nstrobes", s_addr.size(), 6);
    check("t1_w0_addr", 32'(s_addr[0]), 32'h100);
    check("t1_w1_addr", 32'(s_addr[1]), 32'h102);
    check("t1_w2_addr", 32'(s_addr[2]), 32'h104);
    check("t1_w0_data", s_data[0], P0);
    check("t1_w1_data", s_data[1], P1);
    check("t1_w2_data", s_data[2], P2);
    check("t1_rd_flags", {26'd0, s_rd[0], s_rd[1], s_rd[2], s_rd[3], s_rd[4], s_rd[5]}, 32'b000111);
    check("t1_r2_addr", 32'(s_addr[5]), 32'h104);
    check("t1_wr_spacing", s_cyc[1] - s_cyc[0], 3);
    check("t1_done_latency", dc - s_cyc[5], 3);
    check("t1_status", {28'd0, done, pass, timeout, testBusy}, 32'b1100);
    check("t1_err", {16'd0, errorCount}, 32'd0);
    check("t1_readReg", readReg, P2);
    check("t1_no_b2b", {31'd0, b2b}, 32'd0);

    // Single mismatch, restarted from DONE
    corrupt_en = 1; corrupt_addr = 22'h102;
    clear_log();
    do_start(22'h100);
    wait_done(200, dc);
    check("t2_err", {16'd0, errorCount}, 32'd1);
    check("t2_ferr", 32'(firstErrorAddress), 32'h102);
    check("t2_pass", {30'd0, done, pass}, 32'b10);
    check("t2_readReg", readReg, P2);
    corrupt_en = 0;

    // Restart from DONE clears status; start mid-pass is ignored
    clear_log();
    do_start(22'h100);
    check("t3_cleared", {15'd0, errorCount, done}, 32'd0);
    check("t3_ferr_cleared", 32'(firstErrorAddress), 32'd0);
    step(4);
    baseAddress = 22'h200;
    start = 1;
    step(1);
    start = 0;
    wait_done(200, dc);
    check("t3_nstrobes", s_addr.size(), 6);
    check("t3_last_addr", 32'(s_addr[5]), 32'h104);
    check("t3_pass", {31'd0, pass}, 32'd1);

    // Timeout: first read never returns data
    drop_en = 1; drop_addr = 22'h100;
    clear_log();
    do_start(22'h100);
    wait_done(200, dc);
    check("t4_nstrobes", s_addr.size(), 4);
    check("t4_to_latency", dc - s_cyc[3], TO);
    check("t4_status", {29'd0, timeout, done, pass}, 32'b110);
    step(10);
    check("t4_no_more_cmds", s_addr.size(), 4);
    drop_en = 0;

    // Busy back-pressure at start, address wrap
    ext_busy = 1;
    step(20);
    clear_log();
    do_start(22'h3FFFFE);
    check("t5_held", {30'd0, testBusy, commandEnable}, 32'b10);
    step(5);
    check("t5_no_strobe", s_addr.size(), 0);
    ext_busy = 0;
    bcyc = cyc;
    wait_done(200, dc);
    check("t5_first_cyc", s_cyc[0] - bcyc, 1);
    check("t5_a0", 32'(s_addr[0]), 32'h3FFFFE);
    check("t5_a1", 32'(s_addr[1]), 32'h000000);
    check("t5_pass", {31'd0, pass}, 32'd1);

    // Reset during RD_WAIT
    corrupt_en = 1; corrupt_addr = 22'h100;
    clear_log();
    do_start(22'h100);
    nrd = 0;
    for (int i = 0; i < 200 && nrd < 2; i++) begin
      if (commandEnable && commandRead) nrd++;
      if (nrd < 2) step(1);
    end
    check("t6_reached_2nd_read", nrd, 2);
    check("t6_err_before", {16'd0, errorCount}, 32'd1);
    step(1);
    reset = 1;
    step(1);
    check("t6_rst_ctl", {26'd0, commandEnable, commandRead, testBusy, done, pass, timeout}, 32'd0);
    check("t6_rst_addr", 32'(commandAddress), 32'd0);
    check("t6_rst_wdata", writeData, 32'd0);
    check("t6_rst_rreg", readReg, 32'd0);
    check("t6_rst_err", {16'd0, errorCount}, 32'd0);
    check("t6_rst_ferr", 32'(firstErrorAddress), 32'd0);
    step(1);
    reset = 0;
    corrupt_en = 0;
    nlog = s_addr.size();
    step(6);
    check("t6_no_reissue", s_addr.size(), nlog);

    // Stray strobe in IDLE
    stray_data = 32'h12345678;
    stray_rdv = 1;
    step(1);
    stray_rdv = 0;
    check("t7_readReg", readReg, 32'h12345678);
    check("t7_err", {16'd0, errorCount}, 32'd0);
    check("t7_idle", {31'd0, testBusy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
